// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the registered output bundle used by the
// timing generator and its output delay line.
package vga_timing_pkg;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BP     = 48;

   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BP     = 29;

   localparam bit VGA_POL_LOW  = 1'b0;
   localparam bit VGA_POL_HIGH = 1'b1;

   // Coordinates are carried at the widest supported counter width.
   localparam int unsigned VGA_COORD_W = 16;
   localparam int unsigned VGA_FCNT_W  = 16;

   typedef struct packed {
      logic                   hsync;
      logic                   vsync;
      logic                   de;
      logic [VGA_COORD_W-1:0] x;
      logic [VGA_COORD_W-1:0] y;
      logic                   line_start;
      logic                   frame_start;
   } vga_out_t;

   // Bundle value held during reset: syncs inactive, everything else zero.
   function automatic vga_out_t vga_idle(input bit hs_pol, input bit vs_pol);
      vga_out_t b;
      b       = '0;
      b.hsync = ~hs_pol;
      b.vsync = ~vs_pol;
      return b;
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// PIPE-deep, ce-enabled delay line for the VGA output bundle; PIPE=0 is a
// plain wire so the bundle leaves the generator's output register directly.
module vga_sync_delay
   import vga_timing_pkg::*;
#(
   parameter int unsigned PIPE    = 0,
   parameter vga_out_t    RST_VAL = '0
) (
   input  logic     dclk_i,
   input  logic     clr_i,
   input  logic     ce_i,
   input  vga_out_t d_i,
   output vga_out_t q_o
);

   if (PIPE == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{dclk_i, clr_i, ce_i};
      assign q_o        = d_i;
   end else begin : g_pipe
      vga_out_t stage_q [PIPE];

      always_ff @(posedge dclk_i or posedge clr_i) begin
         if (clr_i) begin
            for (int i = 0; i < PIPE; i++) stage_q[i] <= RST_VAL;
         end else if (ce_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < PIPE; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign q_o = stage_q[PIPE-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync/de/
// coordinate decode, optional ce-qualified output delay, frame counter.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter bit          HS_POL   = VGA_POL_LOW,
   parameter bit          VS_POL   = VGA_POL_LOW,
   parameter int unsigned PIPE     = 0,
   parameter int unsigned CNT_W    = 10
) (
   input  logic                  dclk,
   input  logic                  clr,
   input  logic                  ce,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  de,
   output logic [CNT_W-1:0]      x,
   output logic [CNT_W-1:0]      y,
   output logic                  line_start,
   output logic                  frame_start,
   output logic [VGA_FCNT_W-1:0] frame_count
);

   localparam int unsigned H_TOT     = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOT     = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned H_ACT_BEG = H_SYNC + H_BP;
   localparam int unsigned H_ACT_END = H_ACT_BEG + H_ACTIVE;
   localparam int unsigned V_ACT_BEG = V_SYNC + V_BP;
   localparam int unsigned V_ACT_END = V_ACT_BEG + V_ACTIVE;
   localparam vga_out_t    RST_BUNDLE = vga_idle(HS_POL, VS_POL);

   if (H_TOT > 2**CNT_W || V_TOT > 2**CNT_W || PIPE > 7 ||
       CNT_W > VGA_COORD_W) begin : g_bad_cfg
      $error("vga_timing_gen: timing totals exceed counter width or PIPE > 7");
   end

   logic [CNT_W-1:0]      hc_q, hc_d;
   logic [CNT_W-1:0]      vc_q, vc_d;
   logic [VGA_FCNT_W-1:0] fcnt_q, fcnt_d;
   vga_out_t              out_q, out_d;
   vga_out_t              dec_c;
   vga_out_t              pipe_out;
   logic                  h_wrap_c, v_wrap_c;
   logic                  h_act_c, v_act_c;

   // Decode of the current raster position, captured on the next ce edge.
   always_comb begin
      dec_c       = RST_BUNDLE;
      h_act_c     = (32'(hc_q) >= H_ACT_BEG) && (32'(hc_q) < H_ACT_END);
      v_act_c     = (32'(vc_q) >= V_ACT_BEG) && (32'(vc_q) < V_ACT_END);
      dec_c.hsync = (32'(hc_q) < H_SYNC) ? HS_POL : ~HS_POL;
      dec_c.vsync = (32'(vc_q) < V_SYNC) ? VS_POL : ~VS_POL;
      dec_c.de    = h_act_c && v_act_c;
      if (h_act_c && v_act_c) begin
         dec_c.x = VGA_COORD_W'(32'(hc_q) - H_ACT_BEG);
         dec_c.y = VGA_COORD_W'(32'(vc_q) - V_ACT_BEG);
      end
      dec_c.line_start  = (hc_q == '0);
      dec_c.frame_start = (hc_q == '0) && (vc_q == '0);
   end

   // Counter advance; everything holds while ce is low.
   always_comb begin
      hc_d     = hc_q;
      vc_d     = vc_q;
      fcnt_d   = fcnt_q;
      out_d    = out_q;
      h_wrap_c = (32'(hc_q) == H_TOT - 1);
      v_wrap_c = (32'(vc_q) == V_TOT - 1);
      if (ce) begin
         out_d = dec_c;
         hc_d  = h_wrap_c ? '0 : hc_q + CNT_W'(1);
         if (h_wrap_c) begin
            vc_d = v_wrap_c ? '0 : vc_q + CNT_W'(1);
         end
         if (h_wrap_c && v_wrap_c) begin
            fcnt_d = fcnt_q + VGA_FCNT_W'(1);
         end
      end
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         hc_q   <= '0;
         vc_q   <= '0;
         fcnt_q <= '0;
         out_q  <= RST_BUNDLE;
      end else begin
         hc_q   <= hc_d;
         vc_q   <= vc_d;
         fcnt_q <= fcnt_d;
         out_q  <= out_d;
      end
   end

   vga_sync_delay #(
      .PIPE    (PIPE),
      .RST_VAL (RST_BUNDLE)
   ) u_sync_delay (
      .dclk_i (dclk),
      .clr_i  (clr),
      .ce_i   (ce),
      .d_i    (out_q),
      .q_o    (pipe_out)
   );

   if (CNT_W < VGA_COORD_W) begin : g_coord_hi
      // Upper coordinate bits are always zero for narrow counters.
      logic unused_coord_hi;
      assign unused_coord_hi = ^{pipe_out.x[VGA_COORD_W-1:CNT_W],
                                 pipe_out.y[VGA_COORD_W-1:CNT_W]};
   end

   assign hsync       = pipe_out.hsync;
   assign vsync       = pipe_out.vsync;
   assign de          = pipe_out.de;
   assign x           = pipe_out.x[CNT_W-1:0];
   assign y           = pipe_out.y[CNT_W-1:0];
   assign line_start  = pipe_out.line_start;
   assign frame_start = pipe_out.frame_start;
   assign frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (PIPE 0 and 3) plus a tiny
// high-polarity raster driven with ce every fourth clock.
module tb_vga_timing_gen;

   logic dclk = 1'b0;
   logic clr;
   logic ce_a;
   logic ce_s;

   always #5 dclk = ~dclk;

   logic        d_hs, d_vs, d_de, d_ls, d_fs;
   logic [9:0]  d_x, d_y;
   logic [15:0] d_fc;
   logic        p_hs, p_vs, p_de, p_ls, p_fs;
   logic [9:0]  p_x, p_y;
   logic [15:0] p_fc;
   logic        s_hs, s_vs, s_de, s_ls, s_fs;
   logic [3:0]  s_x, s_y;
   logic [15:0] s_fc;

   vga_timing_gen u_def (
      .dclk(dclk), .clr(clr), .ce(ce_a),
      .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
      .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
   );

   vga_timing_gen #(.PIPE(3)) u_p3 (
      .dclk(dclk), .clr(clr), .ce(ce_a),
      .hsync(p_hs), .vsync(p_vs), .de(p_de), .x(p_x), .y(p_y),
      .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
   ) u_sm (
      .dclk(dclk), .clr(clr), .ce(ce_s),
      .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
      .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge dclk);
      @(negedge dclk);
   endtask

   int unsigned de_cnt, hs_cnt;
   int unsigned fs_hi, hs_hi, vs_hi, de_hi, hold_err, rise_n;
   int          rise0, rise1;
   logic        fs_prev;
   logic [31:0] cur_b, prev_b;

   initial begin
      clr  = 1'b1;
      ce_a = 1'b0;
      ce_s = 1'b0;
      repeat (3) tick();

      chk("rst_def_hs", 32'(d_hs), 1);
      chk("rst_def_vs", 32'(d_vs), 1);
      chk("rst_def_de", 32'(d_de), 0);
      chk("rst_def_xy", 32'({d_x, d_y}), 0);
      chk("rst_def_mk", 32'({d_ls, d_fs}), 0);
      chk("rst_def_fc", 32'(d_fc), 0);
      chk("rst_p3_hs",  32'(p_hs), 1);
      chk("rst_sm_hsvs", 32'({s_hs, s_vs}), 0);

      // Default timing, ce every clock, through the first active lines.
      clr    = 1'b0;
      ce_a   = 1'b1;
      de_cnt = 0;
      hs_cnt = 0;
      for (int k = 1; k <= 25800; k++) begin
         tick();
         if (k >= 24801 && k <= 25600) begin
            if (d_de)  de_cnt++;
            if (!d_hs) hs_cnt++;
         end
         case (k)
            1: begin
               chk("k1_fs", 32'(d_fs), 1);
               chk("k1_ls", 32'(d_ls), 1);
               chk("k1_hs", 32'(d_hs), 0);
               chk("k1_vs", 32'(d_vs), 0);
               chk("k1_de", 32'(d_de), 0);
            end
            3: begin
               chk("k3_p3_hs", 32'(p_hs), 1);
               chk("k3_p3_fs", 32'(p_fs), 0);
            end
            4: begin
               chk("k4_p3_hs", 32'(p_hs), 0);
               chk("k4_p3_fs", 32'(p_fs), 1);
            end
            96:  chk("k96_hs",  32'(d_hs), 0);
            97:  chk("k97_hs",  32'(d_hs), 1);
            99:  chk("k99_p3_hs",  32'(p_hs), 0);
            100: chk("k100_p3_hs", 32'(p_hs), 1);
            801: begin
               chk("k801_ls", 32'(d_ls), 1);
               chk("k801_fs", 32'(d_fs), 0);
            end
            1600: chk("k1600_vs", 32'(d_vs), 0);
            1601: chk("k1601_vs", 32'(d_vs), 1);
            24944: chk("de_pre_rise", 32'(d_de), 0);
            24945: begin
               chk("de_rise", 32'(d_de), 1);
               chk("de_rise_x", 32'(d_x), 0);
               chk("de_rise_y", 32'(d_y), 0);
            end
            24947: chk("p3_de_pre_rise", 32'(p_de), 0);
            24948: begin
               chk("p3_de_rise",   32'(p_de), 1);
               chk("p3_de_rise_x", 32'(p_x), 0);
               chk("p3_de_rise_y", 32'(p_y), 0);
            end
            25584: begin
               chk("de_last", 32'(d_de), 1);
               chk("x_last",  32'(d_x), 639);
            end
            25585: begin
               chk("de_fall",   32'(d_de), 0);
               chk("de_fall_x", 32'(d_x), 0);
            end
            25587: begin
               chk("p3_de_last", 32'(p_de), 1);
               chk("p3_x_last",  32'(p_x), 639);
            end
            25588: chk("p3_de_fall", 32'(p_de), 0);
            25800: begin
               chk("mid_de", 32'(d_de), 1);
               chk("mid_x",  32'(d_x), 55);
               chk("mid_y",  32'(d_y), 1);
               chk("mid_fc", 32'(d_fc), 0);
            end
            default: ;
         endcase
      end
      chk("line_de_count", de_cnt, 640);
      chk("line_hs_count", hs_cnt, 96);
      chk("sm_hold_ce0", 32'({s_ls, s_fs, s_de}), 0);

      // Mid-frame clear takes effect without a clock edge.
      clr = 1'b1;
      #1;
      chk("clr_de", 32'(d_de), 0);
      chk("clr_xy", 32'({d_x, d_y}), 0);
      chk("clr_hsvs", 32'({d_hs, d_vs}), 3);
      chk("clr_mk", 32'({d_ls, d_fs}), 0);
      chk("clr_p3_de", 32'(p_de), 0);
      tick();
      tick();
      clr = 1'b0;
      tick();
      chk("rel_fs", 32'(d_fs), 1);
      chk("rel_ls", 32'(d_ls), 1);
      chk("rel_hs", 32'(d_hs), 0);
      chk("rel_fc", 32'(d_fc), 0);
      chk("rel_p3_fs", 32'(p_fs), 0);
      repeat (3) tick();
      chk("rel_p3_fs_d3", 32'(p_fs), 1);
      ce_a = 1'b0;

      // Tiny raster, ce every fourth dclk.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("sm_rst_fc", 32'(s_fc), 0);
      fs_hi    = 0; hs_hi = 0; vs_hi = 0; de_hi = 0;
      hold_err = 0; rise_n = 0; rise0 = -1; rise1 = -1;
      fs_prev  = 1'b0;
      prev_b   = '0;
      for (int j = 0; j < 320; j++) begin
         ce_s = (j % 4 == 0);
         tick();
         cur_b = 32'({s_hs, s_vs, s_de, s_x, s_y, s_ls, s_fs, s_fc});
         if (j % 4 != 0 && cur_b != prev_b) hold_err++;
         prev_b = cur_b;
         if (s_fs) begin
            fs_hi++;
            if (!fs_prev) begin
               if (rise_n == 0) rise0 = j;
               else if (rise_n == 1) rise1 = j;
               rise_n++;
            end
         end
         fs_prev = s_fs;
         if (s_hs) hs_hi++;
         if (s_vs) vs_hi++;
         if (s_de) de_hi++;
         case (j)
            76: begin
               chk("sm_de_first", 32'(s_de), 1);
               chk("sm_xy_first", 32'({s_x, s_y}), 0);
            end
            120: begin
               chk("sm_x_last", 32'(s_x), 3);
               chk("sm_y_last", 32'(s_y), 1);
            end
            155: chk("sm_fc_pre", 32'(s_fc), 0);
            156: chk("sm_fc_inc", 32'(s_fc), 1);
            default: ;
         endcase
      end
      ce_s = 1'b0;
      chk("sm_fs_first_rise", 32'(rise0), 0);
      chk("sm_frame_period", 32'(rise1 - rise0), 160);
      chk("sm_fs_width", fs_hi, 8);
      chk("sm_hs_high", hs_hi, 40);
      chk("sm_vs_high", vs_hi, 64);
      chk("sm_de_high", de_hi, 64);
      chk("sm_hold_between_ce", hold_err, 0);
      chk("sm_fc_end", 32'(s_fc), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 10 / 2 / 29, vertical equivalents in lines.
REQ-004 SHALL have parameters HS_POL / VS_POL, default 0 / 0, active sync level (0 = active-low).
REQ-005 SHALL have parameter PIPE, default 0, range 0..7, extra output delay in pixel periods.
REQ-006 SHALL have parameter CNT_W, default 10, counter and coordinate width.
REQ-007 Ports: dclk  in  1  pixel-domain clock; single clock for the block.
REQ-008 Ports: clr  in  1  reset, asynchronous, active-high.
REQ-009 Ports: ce  in  1  pixel enable; all state advances only when ce=1.
REQ-010 Ports: hsync, vsync  out  1  sync pulses at HS_POL/VS_POL level.
REQ-011 Ports: de  out  1  active-video flag.
REQ-012 Ports: x, y  out  CNT_W  active-area coordinates; 0 when de=0.
REQ-013 Ports: line_start, frame_start  out  1  one-pixel-period markers.
REQ-014 Ports: frame_count  out  16  completed-frame counter.

Function
REQ-015 H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOT likewise; elaboration SHALL fail if either exceeds 2^CNT_W or PIPE>7.
REQ-016 Internal hc SHALL count 0..H_TOT-1 on each ce and wrap to 0; at the wrap, vc SHALL count 0..V_TOT-1 and wrap to 0.
REQ-017 Line order SHALL be: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch; vertical order identical.
REQ-018 hsync SHALL be at HS_POL level iff hc<H_SYNC; vsync at VS_POL level iff vc<V_SYNC.
REQ-019 de SHALL be 1 iff hc and vc are both in their active windows.
REQ-020 x = hc-(H_SYNC+H_BP) and y = vc-(V_SYNC+V_BP) while de=1, else 0.
REQ-021 line_start SHALL be 1 iff hc=0; frame_start 1 iff hc=0 and vc=0.
REQ-022 frame_count SHALL increment, wrapping 65535->0, on the ce where hc and vc both wrap.
REQ-023 All outputs SHALL be registered, decoded from (hc,vc) before the ce edge, then delayed PIPE further ce-qualified stages; total latency is 1+PIPE ce cycles, and all outputs stay mutually aligned.
REQ-024 With ce=0, counters, pipeline and outputs SHALL hold, so markers last exactly one pixel period (ce to ce).
REQ-025 clr mid-frame SHALL abort the frame; after release, the first ce loads the decode of (0,0).

Reset
REQ-026 While clr=1: hc=vc=0; hsync/vsync at inactive level; de=0; x=y=0; line_start=frame_start=0; frame_count=0; all pipeline stages hold these same values.
REQ-027 Reset SHALL take effect without a dclk edge; removal is sampled synchronously by the next dclk edge.

Structure
REQ-028 Package vga_timing_pkg SHALL hold the default 640x480 timing constants, polarity constants and an output-bundle typedef {hsync, vsync, de, x, y, line_start, frame_start}.
REQ-029 Sub-module vga_sync_delay SHALL implement the PIPE-deep, ce-enabled, clr-reset shift register for the output bundle; PIPE=0 instantiates as a wire.

Verification
REQ-030 Defaults, ce=1 -> hsync low 96 of every 800 cycles; de high 640 cycles/line on 480 lines; frame_start period 416800 cycles.
REQ-031 Defaults, PIPE=3 -> de rise at x=0, fall after x=639; y=0..479; all edges 4 ce after the corresponding counter value.
REQ-032 ce high every 4th dclk -> outputs change only on ce cycles; frame_start high 4 dclk; frame period 1667200 dclk.
REQ-033 clr pulsed at hc=400, vc=100 -> outputs at reset values immediately; frame restarts with frame_start 1 ce after release; frame_count=0.
REQ-034 H 4/1/2/1, V 2/1/1/1, HS_POL=VS_POL=1 -> hsync high 1 of 8 cycles; vsync high 1 of 5 lines; frame_count wraps 65535->0 after 65536 frames.
